wash_cycle_controller: RTL and testbench
========================================

# wash_cycle_controller

Sequences one coin-purchased wash cycle on the laundry machine. The block latches the `Mode` word produced by the coin mode-select stage on `Start`, steps the machine through fill / wash / drain / rinse / spin phases timed by an external tick, and drives the valve, motor and pump outputs. `isRunning` is returned to the mode-select stage so that `Mode` freezes while a cycle is in progress.

## Interface
- `FILL_T`, 4: fill duration in ticks.
- `WASH_T_QUICK`, 6: wash duration in ticks, quick cycle.
- `WASH_T_FULL`, 12: wash duration in ticks, full cycle.
- `RINSE_T`, 5: rinse agitation duration in ticks (full cycle only).
- `DRAIN_T`, 3: drain duration in ticks.
- `SPIN_T`, 4: spin duration in ticks.
- `Clk` in 1: the only clock; all state changes on its rising edge.
- `Rst_n` in 1: reset, synchronous and active-low.
- `Mode` in 4: from mode select; `Mode[3:1]` 3'b001 = quick, 3'b101 = full, anything else = no credit.
- `Start` in 1: level; a cycle begins if it is sampled high in IDLE.
- `DoorClosed` in 1: door interlock, 1 = closed.
- `Tick` in 1: one-cycle timebase strobe, 1 tick = 1 time unit.
- `isRunning` out 1: high in every state except IDLE.
- `Phase` out 3: current state encoding (listed below).
- `WaterValve` out 1: inlet valve open.
- `Motor` out 2: 00 off, 01 agitate, 10 spin.
- `DrainPump` out 1: drain pump on.
- `Remaining` out 8: ticks left in the current timed phase.
- `Done` out 1: one-cycle pulse at cycle completion.

## Operation
- States and `Phase` encodings: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, PAUSE=6, FINISH=7.
- Reset value of every output is 0. After reset the state is IDLE, the internal rinse flag is 0 and the latched mode is 0.
- IDLE to FILL: `Start`=1 AND `DoorClosed`=1 AND `Mode[3:1]` is 001 or 101. `Mode[3:1]` is latched on this transition; later `Mode` changes are ignored until IDLE. If any of the three conditions fails, the block stays in IDLE.
- Phase order, quick cycle: FILL → WASH → DRAIN → SPIN → FINISH.
- Phase order, full cycle: FILL → WASH → DRAIN → FILL → RINSE → DRAIN → SPIN → FINISH.
  - The rinse flag is set when the first DRAIN exits in a full cycle.
  - With the flag set, FILL exits to RINSE and the following DRAIN exits to SPIN.
  - The flag clears in FINISH.
- Outputs per state:
  - FILL: `WaterValve`=1.
  - WASH and RINSE: `Motor`=01.
  - DRAIN: `DrainPump`=1.
  - SPIN: `Motor`=10 and `DrainPump`=1.
  - IDLE, PAUSE and FINISH: valve, motor and pump all off.
- Phase counter:
  - On entry to a timed phase the counter loads that phase's duration.
  - The counter decrements by 1 on each cycle with `Tick`=1.
  - The phase exits on the cycle where counter==1 and `Tick`=1.
  - `Remaining` = counter; it is 0 in IDLE and FINISH.
- Door opened (`DoorClosed`=0) in any timed phase:
  - Next cycle the state is PAUSE and all actuators are off.
  - The counter holds and the interrupted phase is saved.
  - `Tick` is ignored in PAUSE.
  - When `DoorClosed`=1 the block returns to the saved phase with the counter unchanged.
- FINISH lasts exactly one cycle with `Done`=1, then goes to IDLE.
- Priority rule: the door check outranks tick expiry. If `Tick` and door-open occur in the same cycle, the block enters PAUSE and the counter does not decrement.
- A counter of 0 is never reachable inside a timed phase. Every duration parameter must be at least 1; an instantiation with any duration of 0 is illegal.
- `Rst_n` low at any point, including mid-cycle or in PAUSE, returns everything to reset values on the next edge. No partial resume.

## Timing
- `Start` sampled at edge N gives FILL, `isRunning`=1 and `WaterValve`=1 as registered outputs after edge N.
- The exit tick at edge M makes the next phase's outputs valid after edge M. Phase transitions take 0 extra cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Quick cycle with default parameters: 4+6+3+4 = 17 ticks from `Start` to `Done`, plus the 1-cycle FINISH.
- Full cycle with default parameters: 4+12+3+4+5+3+4 = 35 ticks.

## Test plan
- Reset, then `Mode`=4'b0010, `Start`=1, door closed, `Tick` every 4 clocks. Expected `Phase` sequence: 1,2,3,5,7,0. `Done` pulses once, 17 ticks after start. `Remaining` in WASH counts 6..1.
- `Mode`=4'b1010, full cycle. Expected `Phase` sequence: 1,2,3,1,4,3,5,7,0. `Done` after 35 ticks. `WaterValve` is high in both FILL visits.
- `Mode`=4'b0000 with `Start`=1, then `Mode`=4'b0010 with `Start`=1 and `DoorClosed`=0. Expected: the block stays in IDLE with `isRunning`=0 in both cases.
- Drop `DoorClosed` in WASH with `Remaining`=4, hold it low for 10 ticks, then close the door. Expected: PAUSE with all actuators off and `Remaining`=4 throughout. The block resumes in WASH with 4 ticks left and the cycle total is unchanged.
- Change `Mode` to 3'b001 mid full cycle. Expected: the full sequence is unaffected.
- Assert `Tick` and door-open in the same cycle. Expected: PAUSE is entered and the counter does not decrement.
- Pulse `Rst_n`=0 for one clock in SPIN. Expected: all outputs 0 and `Phase`=0 at the next edge. A new `Start` runs a clean cycle with the rinse flag cleared.

Source files
------------

// File: rtl/wash_cycle_controller_if.sv
// rtl/wash_cycle_controller_if.sv - mode/start/door/tick inputs and actuator/status outputs of the wash sequencer
interface wash_cycle_controller_if;
  logic [3:0] Mode;
  logic       Start;
  logic       DoorClosed;
  logic       Tick;
  logic       isRunning;
  logic [2:0] Phase;
  logic       WaterValve;
  logic [1:0] Motor;
  logic       DrainPump;
  logic [7:0] Remaining;
  logic       Done;

  modport master (
    output Mode, Start, DoorClosed, Tick,
    input  isRunning, Phase, WaterValve, Motor, DrainPump, Remaining, Done
  );

  modport slave (
    input  Mode, Start, DoorClosed, Tick,
    output isRunning, Phase, WaterValve, Motor, DrainPump, Remaining, Done
  );
endinterface

// File: rtl/wash_cycle_controller.sv
// rtl/wash_cycle_controller.sv - tick-timed fill/wash/drain/rinse/spin sequencer with door-interlock pause
module wash_cycle_controller #(
  parameter int FILL_T       = 4,
  parameter int WASH_T_QUICK = 6,
  parameter int WASH_T_FULL  = 12,
  parameter int RINSE_T      = 5,
  parameter int DRAIN_T      = 3,
  parameter int SPIN_T       = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  wash_cycle_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    WASH   = 3'd2,
    DRAIN  = 3'd3,
    RINSE  = 3'd4,
    SPIN   = 3'd5,
    PAUSE  = 3'd6,
    FINISH = 3'd7
  } state_t;

  localparam logic [2:0] MODE_QUICK = 3'b001;
  localparam logic [2:0] MODE_FULL  = 3'b101;

  state_t     state, state_n;
  state_t     saved, saved_n;
  state_t     nxt;
  logic [7:0] cnt, cnt_n;
  logic       rinse, rinse_n;
  logic [2:0] mode_lat, mode_n;
  logic       unused_mode0;

  assign unused_mode0 = bus.Mode[0];

  // Durations of 0 are illegal, so a loaded counter is always >= 1.
  function automatic logic [7:0] dur(input state_t s, input logic [2:0] m);
    case (s)
      FILL:    dur = 8'(FILL_T);
      WASH:    dur = (m == MODE_FULL) ? 8'(WASH_T_FULL) : 8'(WASH_T_QUICK);
      DRAIN:   dur = 8'(DRAIN_T);
      RINSE:   dur = 8'(RINSE_T);
      SPIN:    dur = 8'(SPIN_T);
      default: dur = 8'd0;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      saved    <= IDLE;
      cnt      <= 8'd0;
      rinse    <= 1'b0;
      mode_lat <= 3'b000;
    end else begin
      state    <= state_n;
      saved    <= saved_n;
      cnt      <= cnt_n;
      rinse    <= rinse_n;
      mode_lat <= mode_n;
    end
  end

  always_comb begin
    nxt = IDLE;
    case (state)
      FILL:        nxt = rinse ? RINSE : WASH;
      WASH, RINSE: nxt = DRAIN;
      DRAIN:       nxt = (!rinse && mode_lat == MODE_FULL) ? FILL : SPIN;
      SPIN:        nxt = FINISH;
      default:     nxt = IDLE;
    endcase
  end

  always_comb begin
    state_n = state;
    saved_n = saved;
    cnt_n   = cnt;
    rinse_n = rinse;
    mode_n  = mode_lat;
    case (state)
      IDLE: begin
        if (bus.Start && bus.DoorClosed &&
            (bus.Mode[3:1] == MODE_QUICK || bus.Mode[3:1] == MODE_FULL)) begin
          state_n = FILL;
          mode_n  = bus.Mode[3:1];
          cnt_n   = dur(FILL, bus.Mode[3:1]);
        end
      end
      PAUSE: begin
        if (bus.DoorClosed) state_n = saved;
      end
      FINISH: begin
        state_n = IDLE;
        rinse_n = 1'b0;
      end
      default: begin
        // Door check outranks tick expiry: an open door freezes the counter.
        if (!bus.DoorClosed) begin
          state_n = PAUSE;
          saved_n = state;
        end else if (bus.Tick) begin
          if (cnt == 8'd1) begin
            state_n = nxt;
            cnt_n   = dur(nxt, mode_lat);
            if (state == DRAIN && !rinse && mode_lat == MODE_FULL) rinse_n = 1'b1;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.isRunning  = (state != IDLE);
    bus.Phase      = state;
    bus.WaterValve = (state == FILL);
    bus.Motor      = 2'b00;
    bus.DrainPump  = (state == DRAIN) || (state == SPIN);
    bus.Remaining  = cnt;
    bus.Done       = (state == FINISH);
    if (state == WASH || state == RINSE) bus.Motor = 2'b01;
    else if (state == SPIN)              bus.Motor = 2'b10;
  end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb/tb_wash_cycle_controller.sv - scoreboard bench for wash_cycle_controller
module tb_wash_cycle_controller;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  wash_cycle_controller_if bus();

  wash_cycle_controller dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] ph;
    logic       running;
    logic       valve;
    logic [1:0] motor;
    logic       pump;
    logic [7:0] rem;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   tick_en = 1'b0;
  int   tick_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected actuator pattern for each phase on entry.
  task automatic exp_ph(input int ph, input int rem);
    exp_t e;
    e.ph = 3'(ph);
    e.running = (ph != 0);
    e.valve = (ph == 1);
    e.motor = (ph == 2 || ph == 4) ? 2'b01 : (ph == 5) ? 2'b10 : 2'b00;
    e.pump = (ph == 3 || ph == 5);
    e.rem = 8'(rem);
    e.done = (ph == 7);
    exp_q.push_back(e);
  endtask

  task automatic exp_quick_tail();
    exp_ph(3, 3); exp_ph(5, 4); exp_ph(7, 0); exp_ph(0, 0);
  endtask

  task automatic exp_full();
    exp_ph(1, 4); exp_ph(2, 12); exp_ph(3, 3); exp_ph(1, 4); exp_ph(4, 5);
    exp_ph(3, 3); exp_ph(5, 4); exp_ph(7, 0); exp_ph(0, 0);
  endtask

  always begin
    @(posedge Clk);
    #1;
    tick_cnt++;
    bus.Tick = tick_en && (tick_cnt % 4 == 0);
  end

  // Monitor: pops an expectation on every Phase change, checks counter behaviour and Done tick totals.
  initial begin
    logic [2:0] pph;
    logic [7:0] prem;
    int used;
    exp_t e;
    pph = 3'd0;
    prem = 8'd0;
    used = 0;
    forever begin
      @(negedge Clk);
      #3;
      if (mon_en) begin
        if (bus.Phase !== pph) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_phase_change");
          end else begin
            e = exp_q.pop_front();
            chk("phase", bus.Phase, e.ph);
            chk("isRunning", bus.isRunning, e.running);
            chk("WaterValve", bus.WaterValve, e.valve);
            chk("Motor", bus.Motor, e.motor);
            chk("DrainPump", bus.DrainPump, e.pump);
            chk("Remaining_entry", bus.Remaining, e.rem);
            chk("Done_level", bus.Done, e.done);
          end
        end else if (bus.Phase == 3'd6) begin
          chk("pause_hold", bus.Remaining, prem);
        end else if (bus.Remaining !== prem) begin
          chk("rem_step", bus.Remaining, prem - 8'd1);
        end
        if (bus.Done === 1'b1) begin
          if (done_q.size() == 0) fail_now("unexpected_done");
          else chk("done_ticks", used, done_q.pop_front());
        end
        if (bus.Phase == 3'd0) used = 0;
        else if (bus.Phase >= 3'd1 && bus.Phase <= 3'd5 && bus.DoorClosed && bus.Tick) used++;
      end
      pph = bus.Phase;
      prem = bus.Remaining;
    end
  end

  task automatic start_run(input logic [3:0] m);
    @(posedge Clk);
    #1;
    bus.Mode = m;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_cond(input int ph, input int rem, input bit need_tick, input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (bus.Phase == 3'(ph) && (rem < 0 || bus.Remaining == 8'(rem)) && (!need_tick || bus.Tick))
        return;
    end
    fail_now({"timeout_", name});
  endtask

  task automatic wait_idle(input string name);
    wait_cond(0, -1, 0, name);
    repeat (3) @(negedge Clk);
    chk({"exp_drained_", name}, exp_q.size(), 0);
    chk({"done_drained_", name}, done_q.size(), 0);
  endtask

  initial begin
    bus.Mode = 4'b0000;
    bus.Start = 1'b0;
    bus.DoorClosed = 1'b1;
    bus.Tick = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_phase", bus.Phase, 0);
    chk("rst_running", bus.isRunning, 0);
    chk("rst_valve", bus.WaterValve, 0);
    chk("rst_motor", bus.Motor, 0);
    chk("rst_pump", bus.DrainPump, 0);
    chk("rst_remaining", bus.Remaining, 0);
    chk("rst_done", bus.Done, 0);
    mon_en = 1'b1;
    tick_en = 1'b1;

    // Quick cycle
    exp_ph(1, 4); exp_ph(2, 6); exp_quick_tail(); done_q.push_back(17);
    start_run(4'b0010);
    wait_idle("quick");

    // Full cycle
    exp_full(); done_q.push_back(35);
    start_run(4'b1010);
    wait_idle("full");

    // No credit, then door open: must stay idle
    bus.Mode = 4'b0000;
    bus.Start = 1'b1;
    repeat (3) @(negedge Clk);
    chk("nocredit_running", bus.isRunning, 0);
    chk("nocredit_phase", bus.Phase, 0);
    bus.Mode = 4'b0010;
    bus.DoorClosed = 1'b0;
    repeat (3) @(negedge Clk);
    chk("dooropen_running", bus.isRunning, 0);
    chk("dooropen_phase", bus.Phase, 0);
    bus.Start = 1'b0;
    bus.DoorClosed = 1'b1;
    repeat (2) @(negedge Clk);

    // Door opened in WASH with 4 left, held for 10 ticks
    exp_ph(1, 4); exp_ph(2, 6); exp_ph(6, 4); exp_ph(2, 4); exp_quick_tail();
    done_q.push_back(17);
    start_run(4'b0010);
    wait_cond(2, 4, 0, "wash4");
    bus.DoorClosed = 1'b0;
    repeat (40) @(negedge Clk);
    chk("pause_phase", bus.Phase, 6);
    chk("pause_motor", bus.Motor, 0);
    bus.DoorClosed = 1'b1;
    wait_idle("door");

    // Mode changed mid full cycle
    exp_full(); done_q.push_back(35);
    start_run(4'b1010);
    wait_cond(2, -1, 0, "mode_wash");
    bus.Mode = 4'b0010;
    wait_idle("modechg");

    // Tick and door-open in the same cycle
    exp_ph(1, 4); exp_ph(2, 6); exp_ph(6, 3); exp_ph(2, 3); exp_quick_tail();
    done_q.push_back(17);
    start_run(4'b0010);
    wait_cond(2, 3, 1, "wash3_tick");
    bus.DoorClosed = 1'b0;
    repeat (3) @(negedge Clk);
    bus.DoorClosed = 1'b1;
    wait_idle("ticktie");

    // Reset in SPIN, then a clean quick cycle
    exp_ph(1, 4); exp_ph(2, 12); exp_ph(3, 3); exp_ph(1, 4); exp_ph(4, 5);
    exp_ph(3, 3); exp_ph(5, 4); exp_ph(0, 0);
    start_run(4'b1010);
    wait_cond(5, -1, 0, "spin");
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("spinrst_phase", bus.Phase, 0);
    chk("spinrst_running", bus.isRunning, 0);
    chk("spinrst_motor", bus.Motor, 0);
    chk("spinrst_pump", bus.DrainPump, 0);
    chk("spinrst_remaining", bus.Remaining, 0);
    repeat (2) @(negedge Clk);
    exp_ph(1, 4); exp_ph(2, 6); exp_quick_tail(); done_q.push_back(17);
    start_run(4'b0010);
    wait_idle("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
